// File: rtl/spi_master.sv
// Byte-wide SPI master, LSB-first, full duplex, all four CPOL/CPHA modes.
// Host handshake: start (sampled while idle) / busy / one-cycle done.
module spi_master #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       CPOL,
    input  logic       CPHA,
    input  logic [7:0] tx_data,
    input  logic       MISO,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       done,
    output logic       sclk,
    output logic       cs,
    output logic       MOSI
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_XFER,
        ST_END
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [4:0]       edge_q, edge_d;
    logic [7:0]       tx_q, tx_d;
    logic             cpol_q, cpol_d;
    logic             cpha_q, cpha_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             cs_q, cs_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;

    logic [4:0]       k;
    logic             div_wrap;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            edge_q     <= '0;
            tx_q       <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            cs_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            edge_q     <= edge_d;
            tx_q       <= tx_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            cs_q       <= cs_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        edge_d     = edge_q;
        tx_d       = tx_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        cs_d       = cs_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        k          = edge_q + 5'd1;
        div_wrap   = (div_q == DIV_LAST);

        unique case (state_q)
            ST_IDLE: begin
                sclk_d = CPOL;
                cs_d   = 1'b1;
                busy_d = 1'b0;
                if (start) begin
                    tx_d    = tx_data;
                    cpol_d  = CPOL;
                    cpha_d  = CPHA;
                    cs_d    = 1'b0;
                    busy_d  = 1'b1;
                    div_d   = '0;
                    edge_d  = '0;
                    if (!CPHA) begin
                        mosi_d = tx_data[0];
                    end
                    state_d = ST_SETUP;
                end
            end
            // SETUP is the wait before edge 1; both states issue edge k = edge_q+1.
            // Edge k carries bit k>>1; odd/even parity against CPHA picks sample vs drive.
            ST_SETUP, ST_XFER: begin
                if (div_wrap) begin
                    div_d  = '0;
                    edge_d = k;
                    sclk_d = ~sclk_q;
                    if (k[0] == ~cpha_q) begin
                        rx_shift_d = {MISO, rx_shift_q[7:1]};
                    end
                    if ((k[0] == cpha_q) && (k != 5'd16)) begin
                        mosi_d = tx_q[k[3:1]];
                    end
                    state_d = (k == 5'd16) ? ST_END : ST_XFER;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_END: begin
                sclk_d = cpol_q;
                if (div_wrap) begin
                    div_d     = '0;
                    cs_d      = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    rx_data_d = rx_shift_q;
                    state_d   = ST_IDLE;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rx_data = rx_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign sclk    = sclk_q;
    assign cs      = cs_q;
    assign MOSI    = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: loopback vector table for CLK_DIV=2, a mode-3
// behavioral slave, and hand sequences for busy-start, back-to-back, reset, CLK_DIV=1.
module tb_spi_master;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, cpol, cpha, miso;
    logic [7:0] tx_data, rx_data;
    logic       busy, done, sclk, cs, mosi;

    logic       start1, cpol1, cpha1;
    logic [7:0] tx1, rx1;
    logic       busy1, done1, sclk1, cs1, mosi1;

    logic       lb;
    logic [7:0] s_tx_cfg;
    logic [7:0] s_sh, s_rx;
    logic       s_miso = 1'b0;
    logic       cs_prev = 1'b1, sclk_prev = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign miso = lb ? mosi : s_miso;

    spi_master #(.CLK_DIV(2)) dut (
        .clk(clk), .reset(reset), .start(start), .CPOL(cpol), .CPHA(cpha),
        .tx_data(tx_data), .MISO(miso), .rx_data(rx_data), .busy(busy),
        .done(done), .sclk(sclk), .cs(cs), .MOSI(mosi)
    );

    spi_master #(.CLK_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .CPOL(cpol1), .CPHA(cpha1),
        .tx_data(tx1), .MISO(mosi1), .rx_data(rx1), .busy(busy1),
        .done(done1), .sclk(sclk1), .cs(cs1), .MOSI(mosi1)
    );

    // Mode-3 slave: drives on falling sclk, captures on rising sclk, LSB-first.
    always @(cs or sclk) begin
        if (cs_prev === 1'b1 && cs === 1'b0) begin
            s_sh = s_tx_cfg;
            s_rx = 8'h00;
        end else if (!cs && !lb && sclk !== sclk_prev) begin
            if (!sclk) begin
                s_miso = s_sh[0];
            end else begin
                s_rx = {mosi, s_rx[7:1]};
                s_sh = s_sh >> 1;
            end
        end
        cs_prev   = cs;
        sclk_prev = sclk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_xfer(input logic pol, input logic pha, input logic [7:0] tx,
                           input int poke_cyc,
                           output int cs_low, output int done_cyc, output int done_cnt,
                           output int leads, output logic [7:0] mosi_seq,
                           output logic idle_ok);
        logic prev;
        cpol = pol; cpha = pha; tx_data = tx; start = 1'b1;
        cs_low = 0; done_cyc = 0; done_cnt = 0; leads = 0;
        mosi_seq = 8'h00; idle_ok = 1'b1; prev = pol;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (c == 1) start = 1'b0;
            if (c == poke_cyc) begin start = 1'b1; tx_data = 8'hFF; end
            if (c == poke_cyc + 1) start = 1'b0;
            if (c == 1 && sclk !== pol) idle_ok = 1'b0;
            if (!cs) cs_low++;
            if (done) begin
                done_cnt++;
                done_cyc = c;
                if (sclk !== pol) idle_ok = 1'b0;
            end
            if (sclk !== prev && sclk !== pol) begin
                if (leads < 8) mosi_seq[leads] = mosi;
                leads++;
            end
            prev = sclk;
        end
    endtask

    typedef struct {
        logic       pol;
        logic       pha;
        logic [7:0] tx;
        logic [7:0] exp_rx;
        logic [7:0] exp_mosi;
    } vec_t;

    vec_t vecs[4];

    int         cs_low, done_cyc, done_cnt, leads, hi, d1, d2, dcnt, toggles;
    logic [7:0] mseq, r1, r2;
    logic       idle_ok, prev1;

    initial begin
        vecs[0] = '{pol: 1'b0, pha: 1'b0, tx: 8'hA5, exp_rx: 8'hA5, exp_mosi: 8'hA5};
        vecs[1] = '{pol: 1'b1, pha: 1'b0, tx: 8'h3C, exp_rx: 8'h3C, exp_mosi: 8'h3C};
        vecs[2] = '{pol: 1'b0, pha: 1'b1, tx: 8'h0F, exp_rx: 8'h0F, exp_mosi: 8'h0F};
        vecs[3] = '{pol: 1'b1, pha: 1'b1, tx: 8'h81, exp_rx: 8'h81, exp_mosi: 8'h81};

        reset = 1'b1; start = 1'b0; cpol = 1'b0; cpha = 1'b0; tx_data = 8'h00;
        start1 = 1'b0; cpol1 = 1'b0; cpha1 = 1'b0; tx1 = 8'h00;
        lb = 1'b1; s_tx_cfg = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_cs",   {31'd0, cs},   32'd1);
        chk("reset_sclk", {31'd0, sclk}, 32'd0);
        chk("reset_mosi", {31'd0, mosi}, 32'd0);
        chk("reset_rx",   {24'd0, rx_data}, 32'h00);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) begin
            do_xfer(vecs[i].pol, vecs[i].pha, vecs[i].tx, 0,
                    cs_low, done_cyc, done_cnt, leads, mseq, idle_ok);
            chk($sformatf("vec%0d_rx", i),      {24'd0, rx_data}, {24'd0, vecs[i].exp_rx});
            chk($sformatf("vec%0d_mosi", i),    {24'd0, mseq},    {24'd0, vecs[i].exp_mosi});
            chk($sformatf("vec%0d_cs_low", i),  cs_low,   32'd34);
            chk($sformatf("vec%0d_done_cyc", i), done_cyc, 32'd35);
            chk($sformatf("vec%0d_done_cnt", i), done_cnt, 32'd1);
            chk($sformatf("vec%0d_leads", i),   leads,    32'd8);
            chk($sformatf("vec%0d_idle", i),    {31'd0, idle_ok}, 32'd1);
        end

        // Mode 3 against the behavioral slave.
        lb = 1'b0; s_tx_cfg = 8'h3C;
        do_xfer(1'b1, 1'b1, 8'hC3, 0, cs_low, done_cyc, done_cnt, leads, mseq, idle_ok);
        chk("m3_rx",       {24'd0, rx_data}, 32'h3C);
        chk("m3_slave_rx", {24'd0, s_rx},    32'hC3);
        chk("m3_idle_hi",  {31'd0, idle_ok}, 32'd1);
        chk("m3_cs_low",   cs_low, 32'd34);
        lb = 1'b1;

        // Start pulse with new data while busy must be ignored.
        do_xfer(1'b0, 1'b0, 8'h33, 10, cs_low, done_cyc, done_cnt, leads, mseq, idle_ok);
        chk("busy_rx",       {24'd0, rx_data}, 32'h33);
        chk("busy_done_cnt", done_cnt, 32'd1);
        chk("busy_cs_low",   cs_low,   32'd34);
        chk("busy_leads",    leads,    32'd8);

        // Back-to-back: start held through the done cycle.
        cpol = 1'b0; cpha = 1'b0; tx_data = 8'h01; start = 1'b1;
        hi = 0; dcnt = 0; d1 = 0; d2 = 0; r1 = 8'h00; r2 = 8'h00;
        for (int c = 1; c <= 75; c++) begin
            @(posedge clk); #1;
            if (c == 1) tx_data = 8'h80;
            if (dcnt == 1 && c == d1 + 1) start = 1'b0;
            if (done) begin
                dcnt++;
                if (dcnt == 1) begin r1 = rx_data; d1 = c; end
                else begin r2 = rx_data; d2 = c; end
            end
            if (cs && dcnt == 1) hi++;
        end
        start = 1'b0;
        chk("b2b_rx1",   {24'd0, r1}, 32'h01);
        chk("b2b_rx2",   {24'd0, r2}, 32'h80);
        chk("b2b_d1",    d1, 32'd35);
        chk("b2b_d2",    d2, 32'd70);
        chk("b2b_cs_hi", hi, 32'd1);
        chk("b2b_dcnt",  dcnt, 32'd2);

        // Reset asserted around sclk edge 7 aborts the transfer.
        repeat (3) @(posedge clk);
        #1;
        cpol = 1'b0; cpha = 1'b0; tx_data = 8'hFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 2; c <= 15; c++) begin
            @(posedge clk); #1;
        end
        chk("rst_pre_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_cs",   {31'd0, cs},   32'd1);
        chk("rst_sclk", {31'd0, sclk}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rx",   {24'd0, rx_data}, 32'h00);
        dcnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) dcnt++;
            @(posedge clk); #1;
        end
        chk("rst_no_done", dcnt, 32'd0);
        do_xfer(1'b0, 1'b0, 8'h5A, 0, cs_low, done_cyc, done_cnt, leads, mseq, idle_ok);
        chk("post_rst_rx",       {24'd0, rx_data}, 32'h5A);
        chk("post_rst_done_cyc", done_cyc, 32'd35);

        // Mode 1 with CLK_DIV=1.
        cpol1 = 1'b0; cpha1 = 1'b1; tx1 = 8'h96; start1 = 1'b1;
        cs_low = 0; toggles = 0; done_cyc = 0; prev1 = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            @(posedge clk); #1;
            if (c == 1) start1 = 1'b0;
            if (!cs1) cs_low++;
            if (done1) done_cyc = c;
            if (c >= 2 && c <= 17 && sclk1 !== prev1) toggles++;
            prev1 = sclk1;
        end
        chk("d1_cs_low",   cs_low,  32'd17);
        chk("d1_toggles",  toggles, 32'd16);
        chk("d1_done_cyc", done_cyc, 32'd18);
        chk("d1_rx",       {24'd0, rx1}, 32'h96);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
